// File: rtl/inv_sub_bytes_seq.sv
// Sequenced inverse SubBytes: LANES shared inverse S-boxes walk a 128-bit AES
// state through a shift register, N = 16/LANES cycles per state.

module InvSubTable (
    input  logic [7:0] inByte,
    output logic [7:0] outByte
);
    // Index 0 is the leftmost byte of the literal.
    localparam logic [0:255][7:0] TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign outByte = TABLE[inByte];
endmodule

module inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] inState,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] outState,
    output logic         busy
);
    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = 8 * LANES;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : gBadLanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [127:0]    work;
    logic [LW-1:0]   subOut;
    logic [127:0]    shifted;

    for (genvar i = 0; i < LANES; i++) begin : gLane
        InvSubTable uSbox (
            .inByte (work[127-8*i -: 8]),
            .outByte(subOut[LW-1-8*i -: 8])
        );
    end

    // Substituted bytes re-enter at the bottom, so after N shifts the
    // register is back in original byte order.
    if (LANES == 16) begin : gWhole
        assign shifted = subOut;
    end else begin : gShift
        assign shifted = {work[127-LW:0], subOut};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inValid) begin
                        work  <= inState;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    work <= shifted;
                    if (cnt == CW'(N - 1)) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (outReady) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign inReady  = (state == IDLE);
    assign outValid = (state == DONE);
    assign busy     = (state != IDLE);
    assign outState = work;
endmodule

// File: doc/inv_sub_bytes_seq.md
# inv_sub_bytes_seq

Sequenced, area-reduced inverse SubBytes engine for the decryption datapath. It accepts one 128-bit AES state over a valid/ready handshake and substitutes LANES bytes per cycle through LANES shared `InvSubTable` S-box instances. It returns the inverse-substituted state over a second valid/ready handshake. It sits between the AddRoundKey/InvShiftRows stages and the round controller in iterative (non-unrolled) decryption builds, and trades latency for 16/LANES fewer S-box instances.

## Interface
Parameters:
- LANES, 4: bytes substituted per cycle; legal values 1, 2, 4, 8, 16. Illegal values are a elaboration error.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; returns the block to IDLE.
- inValid  in  1  inState is valid.
- inReady  out  1  block can accept a state.
- inState  in  128  state to substitute; byte k = bits [127-8k -: 8], k = 0..15.
- outValid  out  1  outState holds a completed result.
- outReady  in  1  consumer accepts outState.
- outState  out  128  substituted state, same byte ordering as inState.
- busy  out  1  high in BUSY or DONE.

## Operation
- N = 16/LANES substitution cycles. Counter width is clog2(N), minimum 1.
- States are IDLE, BUSY and DONE.
- IDLE:
  - inReady = 1.
  - On inValid && inReady, load inState into the 128-bit work register, clear the counter, and go to BUSY.
- BUSY, each cycle:
  - The top LANES bytes of the work register (bits [127 -: 8*LANES]) drive the LANES S-box instances.
  - The work register shifts left by 8*LANES bits, and the S-box outputs fill the low 8*LANES bits in the same byte order.
  - The counter increments.
  - On the cycle with counter == N-1, go to DONE. After N shifts the register holds the result in original byte order.
- DONE:
  - outValid = 1, and outState = work register, held stable.
  - On outReady, go to IDLE. No new state is accepted in the same cycle.
- Output decoding: inReady = (state==IDLE); outValid = (state==DONE); busy = (state!=IDLE). All three are decoded from registered state with no combinational path from inputs.
- outState is driven directly from the work register. It is defined only while outValid=1 and otherwise carries intermediate contents.
- flush:
  - Highest priority in every state.
  - Next state is IDLE; the counter and work register clear to 0.
  - A handshake offered in the same cycle as flush is not accepted.
  - A result in DONE is discarded.
- inValid while not in IDLE is ignored. The producer must hold inValid and inState until inReady.
- outReady outside DONE is ignored.

## Timing
- Reset values (reset_n low, asynchronous):
  - state = IDLE, counter = 0, work register = 0.
  - Hence inReady = 1, outValid = 0, busy = 0, outState = 0.
- Acceptance at edge T:
  - BUSY occupies cycles T+1 .. T+N.
  - outValid = 1 from edge T+N.
  - Latency from acceptance to outValid is N cycles (4 for LANES=4; 16 for LANES=1; 1 for LANES=16).
- Output accepted at edge U: inReady = 1 from edge U.
- Minimum period per state is N+2 cycles with outReady tied high.
- Backpressure: DONE is held indefinitely with outState stable.
- Reset mid-operation: immediate return to the reset values. Neither a partial result nor outValid is ever presented.
- No wrap-around: the counter never exceeds N-1, and the BUSY → DONE transition takes precedence.

## Test plan
- Reset, then all-0x63 input with LANES=4, outReady=1 → outValid high exactly 4 cycles after acceptance; outState = 0x00000000_00000000_00000000_00000000; inReady returns the cycle after the output handshake.
- Input 0x637c777b_f26b6fc5_3001672b_fed7ab76 → outState = 0x00010203_04050607_08090a0b_0c0d0e0f. This checks byte ordering. Repeat for LANES = 1, 2, 8, 16 with latency 16, 8, 2, 1.
- Backpressure: input all 0x00 with outReady=0 for 10 cycles → outValid stays 1, outState = 0x5252…52 stable, inReady = 0 and a new inValid (all 0xff) is ignored. Raise outReady, then accept the all-0xff state → outState = 0x7d7d…7d.
- flush asserted in the 2nd BUSY cycle → IDLE next cycle, outValid never asserts, work register = 0. flush concurrent with inValid in IDLE → no acceptance.
- reset_n pulsed low asynchronously mid-BUSY and also in DONE → outputs at the reset values immediately. A subsequent full transaction produces correct results.
- Back-to-back random states (≥1000) with random inValid/outReady gaps against a reference inverse S-box model → every result matches, with no drops and no duplicates.
